// File: rtl/mem_pkg.sv
// Shared widths and state encoding for the memory access controller.
package mem_pkg;

  localparam int unsigned AddrWDef = 12;
  localparam int unsigned DataWDef = 31;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  typedef enum logic {
    PortOp = 1'b0,
    PortIf = 1'b1
  } port_e;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter: req[0] is the operand port, req[1] the fetch port.
module mem_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Set when the fetch port should win the next tie; cleared means operand wins.
  logic prefer_if_q, prefer_if_d;

  always_comb begin
    grant = req;
    if (req[0] && req[1]) begin
      grant = prefer_if_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prefer_if_d = prefer_if_q;
    if (advance && (grant != 2'b00)) begin
      prefer_if_d = grant[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_if_q <= 1'b0;
    end else begin
      prefer_if_q <= prefer_if_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access controller shared by a fetch port and an operand port.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned ADDR_W  = AddrWDef,
  parameter int unsigned DATA_W  = DataWDef
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_data,
  input  logic              op_req,
  input  logic              op_we,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              op_ready,
  output logic [DATA_W-1:0] op_rdata,
  output logic              err,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic              mem_finish,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  port_e             port_q, port_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              op_ready_q, op_ready_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] op_rdata_q, op_rdata_d;
  logic              err_q, err_d;
  logic [1:0]        grant;

  mem_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({if_req, op_req}),
    .advance (state_q == StIdle),
    .grant   (grant)
  );

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    cnt_d      = cnt_q;
    wr_en_d    = wr_en_q;
    rd_en_d    = rd_en_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_ready_d = 1'b0;
    op_ready_d = 1'b0;
    if_data_d  = if_data_q;
    op_rdata_d = op_rdata_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          state_d = StAccess;
          cnt_d   = '0;
          if (grant[0]) begin
            port_d  = PortOp;
            addr_d  = op_addr;
            wdata_d = op_wdata;
            wr_en_d = op_we;
            rd_en_d = ~op_we;
          end else begin
            port_d  = PortIf;
            addr_d  = if_addr;
            wr_en_d = 1'b0;
            rd_en_d = 1'b1;
          end
        end
      end
      StAccess: begin
        // A finish arriving on the last counted cycle still counts as success.
        if (mem_finish || (cnt_q == CntLast)) begin
          state_d = StDone;
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          if (port_q == PortIf) begin
            if_ready_d = 1'b1;
          end else begin
            op_ready_d = 1'b1;
          end
          if (!mem_finish) begin
            err_d = 1'b1;
          end else if (rd_en_q) begin
            if (port_q == PortIf) begin
              if_data_d = mem_read_data;
            end else begin
              op_rdata_d = mem_read_data;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      port_q     <= PortOp;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ready_q <= 1'b0;
      op_ready_q <= 1'b0;
      if_data_q  <= '0;
      op_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_ready_q <= if_ready_d;
      op_ready_q <= op_ready_d;
      if_data_q  <= if_data_d;
      op_rdata_q <= op_rdata_d;
      err_q      <= err_d;
    end
  end

  assign if_ready         = if_ready_q;
  assign if_data          = if_data_q;
  assign op_ready         = op_ready_q;
  assign op_rdata         = op_rdata_q;
  assign err              = err_q;
  assign mem_write_enable = wr_en_q;
  assign mem_read_enable  = rd_en_q;
  assign mem_addr         = addr_q;
  assign mem_write_data   = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 31;
  localparam int unsigned TO = 8;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_data;
  logic          op_req;
  logic          op_we;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;
  logic          op_ready;
  logic [DW-1:0] op_rdata;
  logic          err;
  logic          mem_write_enable;
  logic          mem_read_enable;
  logic          mem_finish;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  int n_tests;
  int n_fail;

  // Transaction-level model: last read word per port, sticky error, last port granted.
  logic [DW-1:0] m_if_data;
  logic [DW-1:0] m_op_rdata;
  logic          m_err;
  logic          m_last_if;

  mem_access_ctrl #(
    .TIMEOUT (TO),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_ready         (if_ready),
    .if_data          (if_data),
    .op_req           (op_req),
    .op_we            (op_we),
    .op_addr          (op_addr),
    .op_wdata         (op_wdata),
    .op_ready         (op_ready),
    .op_rdata         (op_rdata),
    .err              (err),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_finish       (mem_finish),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; op_req = 1'b0; mem_finish = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    m_if_data = '0; m_op_rdata = '0; m_err = 1'b0; m_last_if = 1'b1;
  endtask

  // Acts as the memory for one transaction: finishes during strobe cycle `lat` (0 = never).
  task automatic serve(input int lat, input logic [DW-1:0] rd, input logic drop,
                       input logic glitch, output int gap, output int nstb, output logic wr,
                       output logic [AW-1:0] a, output logic [DW-1:0] wd, output logic stable,
                       output logic ir, output logic orr, output logic [DW-1:0] ifd,
                       output logic [DW-1:0] opd, output logic errv, output logic quiet);
    gap = 0; nstb = 0; stable = 1'b1;
    mem_finish = glitch;
    mem_read_data = DW'($urandom);
    while (gap < 6) begin
      cycle();
      gap++;
      mem_finish = 1'b0;
      if (mem_write_enable || mem_read_enable) break;
    end
    wr = mem_write_enable; a = mem_addr; wd = mem_write_data;
    while ((mem_write_enable || mem_read_enable) && nstb < 20) begin
      nstb++;
      if (mem_addr !== a || mem_write_data !== wd || mem_write_enable !== wr ||
          mem_read_enable !== ~wr) stable = 1'b0;
      if (drop && nstb == 1) begin if_req = 1'b0; op_req = 1'b0; end
      if (nstb == lat) begin
        mem_finish = 1'b1; mem_read_data = rd;
      end else begin
        mem_read_data = DW'($urandom);
      end
      cycle();
      mem_finish = 1'b0;
    end
    ir = if_ready; orr = op_ready; ifd = if_data; opd = op_rdata; errv = err;
    if (if_ready) if_req = 1'b0;
    if (op_ready) op_req = 1'b0;
    cycle();
    quiet = !if_ready && !op_ready && !mem_write_enable && !mem_read_enable;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if ({if_ready, op_ready} !== 2'b00) begin n_fail++;
      $display("FAIL reset_ready got %b want 00", {if_ready, op_ready}); end
    n_tests++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin n_fail++;
      $display("FAIL reset_strobes got %b want 00", {mem_write_enable, mem_read_enable}); end
    n_tests++; if (err !== 1'b0) begin n_fail++;
      $display("FAIL reset_err got %b want 0", err); end
    n_tests++; if (if_data !== '0 || op_rdata !== '0) begin n_fail++;
      $display("FAIL reset_rdata got %h/%h want 0/0", if_data, op_rdata); end
    n_tests++; if (mem_addr !== '0 || mem_write_data !== '0) begin n_fail++;
      $display("FAIL reset_bus got %h/%h want 0/0", mem_addr, mem_write_data); end
  endtask

  task automatic test_op_write();
    int gap, nstb; logic wr, stable, ir, orr, errv, quiet;
    logic [AW-1:0] a; logic [DW-1:0] wd, ifd, opd;
    op_req = 1'b1; op_we = 1'b1; op_addr = 12'o0123; op_wdata = 31'o01234567012;
    serve(3, '0, 1'b0, 1'b0, gap, nstb, wr, a, wd, stable, ir, orr, ifd, opd, errv, quiet);
    m_last_if = 1'b0;
    n_tests++; if (gap !== 1) begin n_fail++;
      $display("FAIL opw_latency got %0d want 1", gap); end
    n_tests++; if (nstb !== 3) begin n_fail++;
      $display("FAIL opw_strobe_cycles got %0d want 3", nstb); end
    n_tests++; if (wr !== 1'b1 || a !== 12'o0123 || wd !== 31'o01234567012) begin n_fail++;
      $display("FAIL opw_bus got we=%b a=%o d=%o want 1/0123/01234567012", wr, a, wd); end
    n_tests++; if (stable !== 1'b1) begin n_fail++;
      $display("FAIL opw_stable got %b want 1", stable); end
    n_tests++; if ({ir, orr} !== 2'b01 || quiet !== 1'b1) begin n_fail++;
      $display("FAIL opw_ready got %b quiet=%b want 01 quiet=1", {ir, orr}, quiet); end
    n_tests++; if (opd !== m_op_rdata) begin n_fail++;
      $display("FAIL opw_rdata_kept got %h want %h", opd, m_op_rdata); end
  endtask

  task automatic test_if_read();
    int gap, nstb; logic wr, stable, ir, orr, errv, quiet;
    logic [AW-1:0] a; logic [DW-1:0] wd, ifd, opd;
    if_req = 1'b1; if_addr = 12'o7777;
    serve(1, 31'o17, 1'b0, 1'b0, gap, nstb, wr, a, wd, stable, ir, orr, ifd, opd, errv, quiet);
    m_last_if = 1'b1; m_if_data = 31'o17;
    n_tests++; if (gap !== 1 || nstb !== 1) begin n_fail++;
      $display("FAIL ifr_round_trip got gap=%0d strobes=%0d want 1/1", gap, nstb); end
    n_tests++; if (wr !== 1'b0 || a !== 12'o7777) begin n_fail++;
      $display("FAIL ifr_bus got we=%b a=%o want 0/7777", wr, a); end
    n_tests++; if ({ir, orr} !== 2'b10 || quiet !== 1'b1) begin n_fail++;
      $display("FAIL ifr_ready got %b quiet=%b want 10 quiet=1", {ir, orr}, quiet); end
    n_tests++; if (ifd !== m_if_data || opd !== m_op_rdata) begin n_fail++;
      $display("FAIL ifr_data got %h/%h want %h/%h", ifd, opd, m_if_data, m_op_rdata); end
  endtask

  task automatic test_round_robin();
    int gap, nstb; logic wr, stable, ir, orr, errv, quiet, exp_if;
    logic [AW-1:0] a, ai, ao; logic [DW-1:0] wd, ifd, opd, rd;
    ai = AW'($urandom); ao = AW'($urandom);
    if_req = 1'b1; if_addr = ai; op_req = 1'b1; op_we = 1'b0; op_addr = ao;
    for (int i = 0; i < 4; i++) begin
      exp_if = ~m_last_if;
      rd = DW'($urandom);
      serve(1, rd, 1'b0, 1'b0, gap, nstb, wr, a, wd, stable, ir, orr, ifd, opd, errv, quiet);
      m_last_if = exp_if;
      if (exp_if) m_if_data = rd; else m_op_rdata = rd;
      n_tests++; if ({ir, orr} !== {exp_if, ~exp_if} || quiet !== 1'b1) begin n_fail++;
        $display("FAIL rr_grant[%0d] got %b quiet=%b want %b", i, {ir, orr}, quiet,
                 {exp_if, ~exp_if}); end
      n_tests++; if (a !== (exp_if ? ai : ao)) begin n_fail++;
        $display("FAIL rr_addr[%0d] got %h want %h", i, a, exp_if ? ai : ao); end
      n_tests++; if (ifd !== m_if_data || opd !== m_op_rdata) begin n_fail++;
        $display("FAIL rr_data[%0d] got %h/%h want %h/%h", i, ifd, opd, m_if_data,
                 m_op_rdata); end
      if (i < 3) begin
        if (exp_if) begin ai = AW'($urandom); if_addr = ai; if_req = 1'b1; end
        else begin ao = AW'($urandom); op_addr = ao; op_req = 1'b1; end
      end
    end
    if_req = 1'b0; op_req = 1'b0;
  endtask

  task automatic test_finish_vs_timeout();
    int gap, nstb; logic wr, stable, ir, orr, errv, quiet;
    logic [AW-1:0] a; logic [DW-1:0] wd, ifd, opd, rd;
    rd = DW'($urandom);
    if_req = 1'b1; if_addr = AW'($urandom);
    serve(TO, rd, 1'b0, 1'b0, gap, nstb, wr, a, wd, stable, ir, orr, ifd, opd, errv, quiet);
    m_last_if = 1'b1; m_if_data = rd;
    n_tests++; if (nstb !== TO || errv !== 1'b0) begin n_fail++;
      $display("FAIL fvt_finish_wins got strobes=%0d err=%b want %0d/0", nstb, errv, TO); end
    n_tests++; if (ifd !== m_if_data || ir !== 1'b1) begin n_fail++;
      $display("FAIL fvt_data got %h ready=%b want %h/1", ifd, ir, m_if_data); end
  endtask

  task automatic test_timeout();
    int gap, nstb; logic wr, stable, ir, orr, errv, quiet;
    logic [AW-1:0] a; logic [DW-1:0] wd, ifd, opd, rd;
    op_req = 1'b1; op_we = 1'b0; op_addr = AW'($urandom);
    serve(0, '0, 1'b0, 1'b0, gap, nstb, wr, a, wd, stable, ir, orr, ifd, opd, errv, quiet);
    m_last_if = 1'b0; m_err = 1'b1;
    n_tests++; if (nstb !== TO) begin n_fail++;
      $display("FAIL to_strobe_cycles got %0d want %0d", nstb, TO); end
    n_tests++; if ({ir, orr} !== 2'b01 || quiet !== 1'b1) begin n_fail++;
      $display("FAIL to_ready got %b quiet=%b want 01 quiet=1", {ir, orr}, quiet); end
    n_tests++; if (errv !== 1'b1 || opd !== m_op_rdata) begin n_fail++;
      $display("FAIL to_err_data got err=%b d=%h want 1/%h", errv, opd, m_op_rdata); end
    rd = DW'($urandom);
    if_req = 1'b1; if_addr = AW'($urandom);
    serve(2, rd, 1'b0, 1'b0, gap, nstb, wr, a, wd, stable, ir, orr, ifd, opd, errv, quiet);
    m_last_if = 1'b1; m_if_data = rd;
    n_tests++; if (errv !== 1'b1 || err !== 1'b1 || ifd !== m_if_data) begin n_fail++;
      $display("FAIL to_sticky got err=%b/%b d=%h want 1/1/%h", errv, err, ifd, m_if_data); end
  endtask

  task automatic test_reset_mid_access();
    int gap, nstb; logic wr, stable, ir, orr, errv, quiet;
    logic [AW-1:0] a, ai, ao; logic [DW-1:0] wd, ifd, opd, rd;
    op_req = 1'b1; op_we = 1'b1; op_addr = AW'($urandom); op_wdata = DW'($urandom);
    mem_finish = 1'b0;
    cycle();
    n_tests++; if (mem_write_enable !== 1'b1) begin n_fail++;
      $display("FAIL rma_started got %b want 1", mem_write_enable); end
    cycle();
    reset = 1'b1;
    cycle();
    n_tests++; if ({mem_write_enable, mem_read_enable, if_ready, op_ready, err} !== 5'b0)
      begin n_fail++;
      $display("FAIL rma_ctrl got %b want 00000",
               {mem_write_enable, mem_read_enable, if_ready, op_ready, err}); end
    n_tests++; if (if_data !== '0 || op_rdata !== '0 || mem_addr !== '0 ||
                   mem_write_data !== '0) begin n_fail++;
      $display("FAIL rma_data got %h/%h/%h/%h want 0", if_data, op_rdata, mem_addr,
               mem_write_data); end
    m_if_data = '0; m_op_rdata = '0; m_err = 1'b0; m_last_if = 1'b1;
    ai = AW'($urandom); ao = AW'($urandom);
    if_req = 1'b1; if_addr = ai; op_req = 1'b1; op_we = 1'b0; op_addr = ao;
    reset = 1'b0;
    rd = DW'($urandom);
    serve(2, rd, 1'b0, 1'b0, gap, nstb, wr, a, wd, stable, ir, orr, ifd, opd, errv, quiet);
    m_last_if = 1'b0; m_op_rdata = rd;
    n_tests++; if ({ir, orr} !== 2'b01 || a !== ao || opd !== rd) begin n_fail++;
      $display("FAIL rma_op_first got %b a=%h d=%h want 01 a=%h d=%h", {ir, orr}, a, opd,
               ao, rd); end
    rd = DW'($urandom);
    serve(1, rd, 1'b0, 1'b0, gap, nstb, wr, a, wd, stable, ir, orr, ifd, opd, errv, quiet);
    m_last_if = 1'b1; m_if_data = rd;
    n_tests++; if ({ir, orr} !== 2'b10 || a !== ai || ifd !== rd || errv !== 1'b0)
      begin n_fail++;
      $display("FAIL rma_if_next got %b a=%h d=%h err=%b want 10 a=%h d=%h err=0",
               {ir, orr}, a, ifd, errv, ai, rd); end
  endtask

  task automatic test_random();
    int gap, nstb, lat, exp_n; logic wr, stable, ir, orr, errv, quiet, port, we;
    logic [AW-1:0] a, addr; logic [DW-1:0] wd, ifd, opd, rd, wdata;
    for (int i = 0; i < 40; i++) begin
      port = 1'($urandom_range(0, 1));
      we = port ? 1'b0 : 1'($urandom_range(0, 1));
      lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
      addr = AW'($urandom); wdata = DW'($urandom); rd = DW'($urandom);
      if (port) begin if_req = 1'b1; if_addr = addr; end
      else begin op_req = 1'b1; op_we = we; op_addr = addr; op_wdata = wdata; end
      serve(lat, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gap, nstb, wr, a,
            wd, stable, ir, orr, ifd, opd, errv, quiet);
      exp_n = (lat == 0) ? TO : lat;
      if (lat == 0) m_err = 1'b1;
      else if (!we) begin
        if (port) m_if_data = rd; else m_op_rdata = rd;
      end
      n_tests++; if (gap !== 1 || nstb !== exp_n || stable !== 1'b1) begin n_fail++;
        $display("FAIL rand[%0d] timing got gap=%0d strobes=%0d stable=%b want 1/%0d/1",
                 i, gap, nstb, stable, exp_n); end
      n_tests++; if (wr !== we || a !== addr || (we && wd !== wdata)) begin n_fail++;
        $display("FAIL rand[%0d] bus got we=%b a=%h d=%h want %b/%h/%h", i, wr, a, wd, we,
                 addr, wdata); end
      n_tests++; if ({ir, orr} !== {port, ~port} || quiet !== 1'b1) begin n_fail++;
        $display("FAIL rand[%0d] ready got %b quiet=%b want %b", i, {ir, orr}, quiet,
                 {port, ~port}); end
      n_tests++; if (ifd !== m_if_data || opd !== m_op_rdata || errv !== m_err) begin
        n_fail++;
        $display("FAIL rand[%0d] state got %h/%h/%b want %h/%h/%b", i, ifd, opd, errv,
                 m_if_data, m_op_rdata, m_err); end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; op_req = 1'b0; op_we = 1'b0;
    op_addr = '0; op_wdata = '0; mem_finish = 1'b0; mem_read_data = '0;
    test_reset();
    test_op_write();
    test_if_read();
    test_round_robin();
    test_finish_vs_timeout();
    test_timeout();
    test_reset_mid_access();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
